tlul_txn_checker: RTL and testbench
===================================

# tlul_txn_checker

Parametrised, multi-channel TL-UL protocol checker for the fuzzing harnesses. It passively monitors `NumChannels` host-to-device links and tracks which source IDs are outstanding per channel. It flags duplicate sources, orphan responses, response-opcode mismatches and A-channel stability violations. It sits in the harness top beside the DUT and gives the fuzzer a sticky, first-error-captured verdict instead of ad-hoc per-design assertions.

## Interface
- `NumChannels`, default 1: number of monitored TL-UL links (1..8).
- `SourceWidth`, default 8: width of the `a_source`/`d_source` bits that are tracked, taken as the LSBs of the field (1..8).
- `CntWidth`, default 32: width of the per-channel statistics counters.
- `clk_i` input 1: single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `tl_h2d_i` input `tlul_pkg::tl_h2d_t [NumChannels]`: host-to-device link per channel.
- `tl_d2h_i` input `tlul_pkg::tl_d2h_t [NumChannels]`: device-to-host link per channel.
- `err_o` output 1: sticky error flag.
- `err_code_o` output `err_code_e` (3 bits): code of the first captured error.
- `err_chan_o` output `$clog2(NumChannels)` (minimum 1 bit): channel of the first captured error.
- `pending_o` output `NumChannels`: per-channel flag, set when any source is outstanding.
- `idle_o` output 1: set when no channel has anything outstanding.
- `txn_cnt_o` output `CntWidth [NumChannels]`: completed transactions per channel.

## Operation
- An A handshake (`a_hs`) is `a_valid && a_ready`. A D handshake (`d_hs`) is `d_valid && d_ready`.
- Each channel holds two `2^SourceWidth`-bit vectors:
  - `pend`: set when the source is outstanding.
  - `isrd`: set when the outstanding request is a Get.
- Update order within a cycle: the D handshake is evaluated first against the current `pend`, then the A handshake against the updated value.
- D handshake, `pend[d_source]` set:
  - Clear the bit.
  - Check opcode: a Get requires `AccessAckData`; a PutFull/PutPartial requires `AccessAck`. Any other pairing raises `ErrOpMismatch`.
  - Increment `txn_cnt`.
- D handshake, `pend[d_source]` clear: raise `ErrOrphanRsp`. `pend` is unchanged and the counter does not increment.
- A handshake, source still pending after the D step: raise `ErrDupSource`. The bit stays set and `isrd` is overwritten.
- A handshake, source not pending: set `pend`, and write `isrd` = (opcode == Get).
- A-channel stability is checked per channel:
  - Register `hold` = `a_valid && !a_ready`, plus a snapshot of opcode, address, source, size, mask and data.
  - If `hold` was set last cycle and this cycle `a_valid` is low or any snapshot field differs, raise `ErrAStable`.
- Error capture:
  - The first error latches `err_o`, `err_code_o` and `err_chan_o`. The latch is sticky until reset; later errors are ignored.
  - Same-cycle tie-break: lowest channel wins. Within a channel, priority is ErrAStable > ErrOrphanRsp > ErrOpMismatch > ErrDupSource.
- Flags: `pending_o[c]` = `|pend_c`. `idle_o` = `~|pending_o`.
- `txn_cnt` saturates at all-ones and does not wrap.

## Timing
- Every output is registered, so there is 1 cycle of latency from the offending handshake edge to `err_o`.
- `pending_o` and `idle_o` reflect `pend` after the update, so they change 1 cycle after the handshake.
- A same-cycle D+A handshake on the same source that was previously pending is legal: the response retires, then the new request re-arms the bit, and `pending_o` stays high.
- A same-cycle D+A handshake on the same source that was not previously pending raises `ErrOrphanRsp`. The A side then sets the bit.
- Reset values: `err_o` 0, `err_code_o` ErrNone (0), `err_chan_o` 0, `pending_o` 0, `idle_o` 1, `txn_cnt_o` 0.
- All vectors and snapshots clear on reset. Asserting reset mid-transaction discards all tracking, and no error is raised for responses in flight across reset.

## Configuration
- `HWF_TLUL_CHECKER_STATS_EN` defined: the `txn_cnt` registers are instantiated and `txn_cnt_o` behaves as described.
- Macro undefined: no counter flops are built and `txn_cnt_o` is tied to 0. Error checking is unaffected.

## Structure
- `tlul_txn_checker_pkg` holds:
  - `err_code_e`: ErrNone=0, ErrAStable=1, ErrOrphanRsp=2, ErrOpMismatch=3, ErrDupSource=4.
  - The `a_snapshot_t` struct.
  - `MaxChannels` = 8.
- Sub-module `tlul_txn_checker_chan` contains one channel's `pend`/`isrd` vectors, stability snapshot, counter and error-valid/code outputs. The top generates `NumChannels` instances and performs the priority capture.

## Test plan
- Get on ch0 with source 0x05, answered by AccessAckData 3 cycles later: `pending_o[0]` goes 1 then 0, `idle_o` returns to 1, `txn_cnt_o[0]` = 1, `err_o` stays 0.
- AccessAck with d_source 0x11 and nothing pending: `err_o`=1 and `err_code_o`=2 one cycle later.
- PutFull with source 0x02, answered by AccessAckData: `err_code_o`=3.
- Two Gets with source 0x07 and no response between them: `err_code_o`=4, with `pending_o` still 1.
- `a_valid` held with `a_ready`=0 while address changes 0x100 -> 0x104: `err_code_o`=1.
- `NumChannels`=2, ch1 orphan and ch0 dup source in the same cycle: `err_chan_o`=0 and `err_code_o`=4. A later ch1 error leaves the captured values unchanged.
- Reset mid-transaction: `idle_o`=1 afterwards, and a later response for the old source raises `ErrOrphanRsp`.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL link types shared by the harness and the protocol checker.
package tlul_pkg;

   localparam int unsigned TlAw  = 32;
   localparam int unsigned TlDw  = 32;
   localparam int unsigned TlSzw = 2;
   localparam int unsigned TlAiw = 8;
   localparam int unsigned TlDbw = TlDw / 8;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic             a_valid;
      tl_a_op_e         a_opcode;
      logic [TlSzw-1:0] a_size;
      logic [TlAiw-1:0] a_source;
      logic [TlAw-1:0]  a_address;
      logic [TlDbw-1:0] a_mask;
      logic [TlDw-1:0]  a_data;
      logic             d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic             d_valid;
      tl_d_op_e         d_opcode;
      logic [TlSzw-1:0] d_size;
      logic [TlAiw-1:0] d_source;
      logic [TlDw-1:0]  d_data;
      logic             d_error;
      logic             a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_txn_checker_pkg.sv
// Types shared by the TL-UL transaction checker top and its per-channel tracker.
package tlul_txn_checker_pkg;

   import tlul_pkg::*;

   localparam int unsigned MaxChannels = 8;

   typedef enum logic [2:0] {
      ErrNone       = 3'd0,
      ErrAStable    = 3'd1,
      ErrOrphanRsp  = 3'd2,
      ErrOpMismatch = 3'd3,
      ErrDupSource  = 3'd4
   } err_code_e;

   typedef struct packed {
      tl_a_op_e         opcode;
      logic [TlAw-1:0]  address;
      logic [TlAiw-1:0] source;
      logic [TlSzw-1:0] size;
      logic [TlDbw-1:0] mask;
      logic [TlDw-1:0]  data;
   } a_snapshot_t;

   function automatic a_snapshot_t snap_of(tl_h2d_t h);
      a_snapshot_t s;
      s.opcode  = h.a_opcode;
      s.address = h.a_address;
      s.source  = h.a_source;
      s.size    = h.a_size;
      s.mask    = h.a_mask;
      s.data    = h.a_data;
      return s;
   endfunction

endpackage

// File: rtl/tlul_txn_checker_chan.sv
// One monitored TL-UL link: outstanding-source tracking, A stability and stats.
// Counter is built only when HWF_TLUL_CHECKER_STATS_EN is defined.
module tlul_txn_checker_chan
   import tlul_pkg::*;
   import tlul_txn_checker_pkg::*;
#(
   parameter int unsigned SourceWidth = 8,
   parameter int unsigned CntWidth    = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  tl_h2d_t             tl_h2d_i,
   input  tl_d2h_t             tl_d2h_i,
   output logic                err_valid_c,
   output err_code_e           err_code_c,
   output logic                pending_c,
   output logic [CntWidth-1:0] txn_cnt_o
);

   localparam int unsigned NumSrc = 1 << SourceWidth;

   logic [NumSrc-1:0]      pend_q, pend_d;
   logic [NumSrc-1:0]      isrd_q, isrd_d;
   logic                   hold_q;
   a_snapshot_t            snap_q, snap_cur;
   logic [SourceWidth-1:0] a_src, d_src;
   logic                   a_hs, d_hs;
   logic                   orphan, op_mis, dup, a_unstable;

   assign a_src    = tl_h2d_i.a_source[SourceWidth-1:0];
   assign d_src    = tl_d2h_i.d_source[SourceWidth-1:0];
   assign a_hs     = tl_h2d_i.a_valid && tl_d2h_i.a_ready;
   assign d_hs     = tl_d2h_i.d_valid && tl_h2d_i.d_ready;
   assign snap_cur = snap_of(tl_h2d_i);

   // A request that was stalled must be re-presented unchanged.
   assign a_unstable = hold_q && (!tl_h2d_i.a_valid || (snap_cur != snap_q));

   // Response retires first, then the request sees the updated vector.
   always_comb begin
      pend_d = pend_q;
      isrd_d = isrd_q;
      orphan = 1'b0;
      op_mis = 1'b0;
      dup    = 1'b0;
      if (d_hs) begin
         if (pend_q[d_src]) begin
            pend_d[d_src] = 1'b0;
            op_mis = isrd_q[d_src] ? (tl_d2h_i.d_opcode != AccessAckData)
                                   : (tl_d2h_i.d_opcode != AccessAck);
         end else begin
            orphan = 1'b1;
         end
      end
      if (a_hs) begin
         dup           = pend_d[a_src];
         pend_d[a_src] = 1'b1;
         isrd_d[a_src] = (tl_h2d_i.a_opcode == Get);
      end
   end

   always_comb begin
      err_valid_c = a_unstable || orphan || op_mis || dup;
      err_code_c  = ErrNone;
      if (a_unstable)  err_code_c = ErrAStable;
      else if (orphan) err_code_c = ErrOrphanRsp;
      else if (op_mis) err_code_c = ErrOpMismatch;
      else if (dup)    err_code_c = ErrDupSource;
   end

   assign pending_c = |pend_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         isrd_q <= '0;
         hold_q <= 1'b0;
         snap_q <= '0;
      end else begin
         pend_q <= pend_d;
         isrd_q <= isrd_d;
         hold_q <= tl_h2d_i.a_valid && !tl_d2h_i.a_ready;
         snap_q <= snap_cur;
      end
   end

`ifdef HWF_TLUL_CHECKER_STATS_EN
   logic                cnt_inc;
   logic [CntWidth-1:0] cnt_q;

   assign cnt_inc = d_hs && pend_q[d_src];

   // Saturating completed-transaction count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                      cnt_q <= '0;
      else if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CntWidth'(1);
   end

   assign txn_cnt_o = cnt_q;
`else
   assign txn_cnt_o = '0;
`endif

   logic unused_d2h;
   assign unused_d2h = ^{tl_d2h_i.d_size, tl_d2h_i.d_data, tl_d2h_i.d_error,
                         tl_d2h_i.d_source};

endmodule

// File: rtl/tlul_txn_checker.sv
// Multi-channel TL-UL protocol checker with sticky first-error capture.
// Define HWF_TLUL_CHECKER_STATS_EN to build the per-channel transaction counters.
module tlul_txn_checker
   import tlul_pkg::*;
   import tlul_txn_checker_pkg::*;
#(
   parameter  int unsigned NumChannels = 1,
   parameter  int unsigned SourceWidth = 8,
   parameter  int unsigned CntWidth    = 32,
   localparam int unsigned ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  tl_h2d_t                tl_h2d_i [NumChannels],
   input  tl_d2h_t                tl_d2h_i [NumChannels],
   output logic                   err_o,
   output err_code_e              err_code_o,
   output logic [ChanW-1:0]       err_chan_o,
   output logic [NumChannels-1:0] pending_o,
   output logic                   idle_o,
   output logic [CntWidth-1:0]    txn_cnt_o [NumChannels]
);

   logic [NumChannels-1:0] chan_err;
   err_code_e              chan_code [NumChannels];
   logic [NumChannels-1:0] chan_pending;
   logic                   hit;
   err_code_e              sel_code;
   logic [ChanW-1:0]       sel_chan;

   for (genvar c = 0; c < NumChannels; c++) begin : g_chan
      tlul_txn_checker_chan #(
         .SourceWidth(SourceWidth),
         .CntWidth   (CntWidth)
      ) u_chan (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .tl_h2d_i   (tl_h2d_i[c]),
         .tl_d2h_i   (tl_d2h_i[c]),
         .err_valid_c(chan_err[c]),
         .err_code_c (chan_code[c]),
         .pending_c  (chan_pending[c]),
         .txn_cnt_o  (txn_cnt_o[c])
      );
   end

   // Scan high-to-low so the lowest erroring channel is selected last.
   always_comb begin
      hit      = 1'b0;
      sel_code = ErrNone;
      sel_chan = '0;
      for (int c = int'(NumChannels) - 1; c >= 0; c--) begin
         if (chan_err[c]) begin
            hit      = 1'b1;
            sel_code = chan_code[c];
            sel_chan = ChanW'(c);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o      <= 1'b0;
         err_code_o <= ErrNone;
         err_chan_o <= '0;
         pending_o  <= '0;
         idle_o     <= 1'b1;
      end else begin
         if (hit && !err_o) begin
            err_o      <= 1'b1;
            err_code_o <= sel_code;
            err_chan_o <= sel_chan;
         end
         pending_o <= chan_pending;
         idle_o    <= ~|chan_pending;
      end
   end

endmodule

// File: tb/tb_tlul_txn_checker.sv
// Directed bench for tlul_txn_checker with two monitored channels.
module tb_tlul_txn_checker;

   import tlul_pkg::*;
   import tlul_txn_checker_pkg::*;

   localparam int unsigned NumCh = 2;
   localparam int unsigned CntW  = 32;
`ifdef HWF_TLUL_CHECKER_STATS_EN
   localparam int unsigned CntOn = 1;
`else
   localparam int unsigned CntOn = 0;
`endif

   logic            clk;
   logic            rst_n;
   tl_h2d_t         h2d [NumCh];
   tl_d2h_t         d2h [NumCh];
   logic            err;
   err_code_e       err_code;
   logic [0:0]      err_chan;
   logic [NumCh-1:0] pending;
   logic            idle;
   logic [CntW-1:0] txn_cnt [NumCh];

   int n_checks = 0;
   int n_errors = 0;

   tlul_txn_checker #(
      .NumChannels(NumCh),
      .SourceWidth(8),
      .CntWidth   (CntW)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .tl_h2d_i  (h2d),
      .tl_d2h_i  (d2h),
      .err_o     (err),
      .err_code_o(err_code),
      .err_chan_o(err_chan),
      .pending_o (pending),
      .idle_o    (idle),
      .txn_cnt_o (txn_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      for (int c = 0; c < int'(NumCh); c++) begin
         h2d[c]         = '0;
         h2d[c].d_ready = 1'b1;
         d2h[c]         = '0;
         d2h[c].a_ready = 1'b1;
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_bus();
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic req(input int c, input tl_a_op_e op, input logic [7:0] src,
                      input logic [31:0] addr);
      h2d[c].a_valid   = 1'b1;
      h2d[c].a_opcode  = op;
      h2d[c].a_source  = src;
      h2d[c].a_address = addr;
      h2d[c].a_size    = 2'd2;
      h2d[c].a_mask    = 4'hf;
      h2d[c].a_data    = addr ^ 32'hA5A5_0000;
   endtask

   task automatic rsp(input int c, input tl_d_op_e op, input logic [7:0] src);
      d2h[c].d_valid  = 1'b1;
      d2h[c].d_opcode = op;
      d2h[c].d_source = src;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_bus();
      step(2);
      rst_n = 1'b1;
      step(1);

      // reset state
      check("rst_err",      32'(err),        32'd0);
      check("rst_code",     32'(err_code),   32'd0);
      check("rst_chan",     32'(err_chan),   32'd0);
      check("rst_pending",  32'(pending),    32'd0);
      check("rst_idle",     32'(idle),       32'd1);
      check("rst_cnt0",     32'(txn_cnt[0]), 32'd0);
      check("rst_cnt1",     32'(txn_cnt[1]), 32'd0);

      // Get src 0x05, AccessAckData three cycles later
      req(0, Get, 8'h05, 32'h40);
      step(1);
      idle_bus();
      check("get_pending",  32'(pending),    32'd1);
      check("get_idle",     32'(idle),       32'd0);
      step(2);
      check("get_wait_pend", 32'(pending),   32'd1);
      rsp(0, AccessAckData, 8'h05);
      step(1);
      idle_bus();
      check("get_done_pend", 32'(pending),   32'd0);
      check("get_done_idle", 32'(idle),      32'd1);
      check("get_done_cnt",  32'(txn_cnt[0]), 32'(CntOn));
      check("get_done_err",  32'(err),       32'd0);

      // orphan response
      apply_reset();
      rsp(0, AccessAck, 8'h11);
      step(1);
      idle_bus();
      check("orphan_err",   32'(err),        32'd1);
      check("orphan_code",  32'(err_code),   32'd2);
      check("orphan_cnt",   32'(txn_cnt[0]), 32'd0);

      // PutFull answered with data
      apply_reset();
      req(0, PutFullData, 8'h02, 32'h80);
      step(1);
      idle_bus();
      rsp(0, AccessAckData, 8'h02);
      step(1);
      idle_bus();
      check("opmis_code",   32'(err_code),   32'd3);
      check("opmis_cnt",    32'(txn_cnt[0]), 32'(CntOn));
      check("opmis_pend",   32'(pending),    32'd0);

      // duplicate source
      apply_reset();
      req(0, Get, 8'h07, 32'h10);
      step(1);
      req(0, Get, 8'h07, 32'h14);
      step(1);
      idle_bus();
      check("dup_code",     32'(err_code),   32'd4);
      check("dup_pending",  32'(pending),    32'd1);

      // address changes while stalled
      apply_reset();
      req(0, Get, 8'h01, 32'h100);
      d2h[0].a_ready = 1'b0;
      step(1);
      check("stable_hold_err", 32'(err),     32'd0);
      h2d[0].a_address = 32'h104;
      step(1);
      idle_bus();
      check("stable_err",   32'(err),        32'd1);
      check("stable_code",  32'(err_code),   32'd1);
      check("stable_pend",  32'(pending),    32'd0);

      // ch1 orphan vs ch0 dup in the same cycle
      apply_reset();
      req(0, Get, 8'h03, 32'h10);
      step(1);
      idle_bus();
      req(0, Get, 8'h03, 32'h20);
      rsp(1, AccessAck, 8'h09);
      step(1);
      idle_bus();
      check("tie_err",      32'(err),        32'd1);
      check("tie_chan",     32'(err_chan),   32'd0);
      check("tie_code",     32'(err_code),   32'd4);
      rsp(1, AccessAck, 8'h09);
      step(1);
      idle_bus();
      check("sticky_chan",  32'(err_chan),   32'd0);
      check("sticky_code",  32'(err_code),   32'd4);

      // reset mid-transaction
      apply_reset();
      req(0, Get, 8'h20, 32'h30);
      step(1);
      idle_bus();
      check("midrst_pend",  32'(pending),    32'd1);
      apply_reset();
      check("midrst_idle",  32'(idle),       32'd1);
      check("midrst_err",   32'(err),        32'd0);
      rsp(0, AccessAckData, 8'h20);
      step(1);
      idle_bus();
      check("midrst_code",  32'(err_code),   32'd2);

      // same-cycle retire and re-arm of a pending source
      apply_reset();
      req(0, Get, 8'h04, 32'h50);
      step(1);
      idle_bus();
      req(0, Get, 8'h04, 32'h54);
      rsp(0, AccessAckData, 8'h04);
      step(1);
      idle_bus();
      check("rearm_err",    32'(err),        32'd0);
      check("rearm_pend",   32'(pending),    32'd1);
      check("rearm_cnt",    32'(txn_cnt[0]), 32'(CntOn));
      rsp(0, AccessAckData, 8'h04);
      step(1);
      idle_bus();
      check("rearm_done_idle", 32'(idle),    32'd1);
      check("rearm_done_cnt",  32'(txn_cnt[0]), 32'(2 * CntOn));
      check("rearm_done_err",  32'(err),     32'd0);

      // same-cycle D+A on a source that was not pending
      apply_reset();
      req(0, Get, 8'h06, 32'h60);
      rsp(0, AccessAckData, 8'h06);
      step(1);
      idle_bus();
      check("dpa_code",     32'(err_code),   32'd2);
      check("dpa_pend",     32'(pending),    32'd1);
      check("dpa_cnt",      32'(txn_cnt[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
